mux_arbiter: RTL
================

# mux_arbiter

Round-robin arbiter that shares one W-bit output channel between N requesters by driving the select of a mux. Each requester presents valid/data/last; the arbiter grants one requester for a whole burst, steers its data to the output, and rotates priority after each release. Sits between N producer blocks and a single consumer with a valid/ready interface.

## Interface
- N, default 4: number of requesters, 2..8.
- W, default 8: data width per requester.
- MAX_BURST, default 4: beat cap per grant; only used when MUX_ARB_BURST_CAP_EN is defined; range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  N  per-requester valid.
- req_data  input  N*W  requester i occupies bits [i*W +: W].
- req_last  input  N  per-requester end-of-burst flag, qualified by req_valid.
- req_ready  output  N  one-hot or zero; bit i = granted(i) & out_ready.
- out_valid  output  1  req_valid of granted requester, 0 when none granted.
- out_data  output  W  req_data of granted requester, 0 when none granted.
- out_last  output  1  req_last of granted requester, 0 when none granted.
- out_ready  input  1  consumer ready.
- sel  output  clog2(N)  registered index of granted requester (mux select).
- grant  output  N  registered one-hot grant.
- busy  output  1  1 in GRANT state.

## Operation
- Two states: IDLE, GRANT.
- IDLE: grant=0, busy=0. If any req_valid is 1, pick winner by round-robin starting at index ptr, searching ptr, ptr+1, … mod N; register grant/sel to winner; go to GRANT. If none valid, stay.
- GRANT: output path is combinational from registered sel. A beat transfers when out_valid & out_ready.
- Release condition: transfer with out_last=1 (or cap reached, see Configuration). On release: next state IDLE, ptr <= (sel+1) mod N, grant cleared.
- Granted requester deasserting req_valid mid-burst does not release grant; channel stalls.
- Non-granted requesters see req_ready=0; their valid/data are ignored.
- ptr and beat counter are log2-width registers; ptr wraps N-1 -> 0.
- Reset (any time, including mid-burst): state IDLE, ptr=0, grant=0, sel=0, beat counter=0, busy=0; out_valid, out_last, out_data, req_ready all 0 immediately.

## Timing
- Arbitration latency: request sampled in IDLE at edge t; grant, sel, busy valid after edge t; first beat can transfer in cycle after edge t.
- Burst of B beats with out_ready=1 holds channel for B cycles, then one IDLE bubble cycle before next grant (max throughput B/(B+1)).
- req_ready and out_valid are combinational from registered grant and inputs; no combinational path from out_ready to out_valid.
- Simultaneous requests: lowest index at or after ptr wins; ptr=0 after reset, so requester 0 wins first tie.
- Requester releasing and re-requesting immediately is last in priority order at next arbitration.

## Configuration
- MUX_ARB_BURST_CAP_EN defined: beat counter increments per transfer in GRANT; transfer when counter == MAX_BURST-1 releases grant even if out_last=0 (counter cleared, ptr advanced); out_last is not forced. Preempted requester re-arbitrates normally and continues its burst on next grant.
- Not defined: no counter; grant held until transfer with out_last=1; MAX_BURST ignored.

## Test plan
- Reset: rst_n low mid-burst with req_valid=4'b1111 -> all outputs 0 same cycle, after rst_n high requester 0 granted first (sel=0).
- Single requester: req_valid=4'b0100, 3 beats data 0x11,0x22,0x33, last on 0x33, out_ready=1 -> sel=2, out_data sequence 0x11,0x22,0x33, then busy=0 one cycle.
- Rotation: all four valid, each burst 1 beat last=1 -> grant order 0,1,2,3,0, one bubble between grants.
- Backpressure: granted requester 1, out_ready=0 for 3 cycles -> req_ready=4'b0000, out_data held stable, no grant change; out_ready=1 -> beat transfers.
- Valid gap: granted requester 3 drops req_valid for 2 cycles mid-burst while requester 0 valid -> grant stays 4'b1000, out_valid=0, burst resumes.
- Cap (MUX_ARB_BURST_CAP_EN, MAX_BURST=4): requesters 0 and 1 each send 6-beat bursts -> grant sequence 0(4 beats),1(4),0(2, last),1(2, last).

Source files
------------

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin burst arbiter steering N requesters onto one valid/ready channel.
// Define MUX_ARB_BURST_CAP_EN to force a release after MAX_BURST beats of one grant.
module mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] sel,
  output logic [N-1:0]         grant,
  output logic                 busy
);
  localparam int SW = $clog2(N);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [SW-1:0] ptr, ptr_n, sel_n, win, idx;
  logic [N-1:0] grant_n;
  logic xfer, rel, cap_hit;
  if (N < 2 || N > 8 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
    $error("mux_arbiter: parameter out of range");
  end
  assign busy = state == GRANT;
  assign out_valid = busy & req_valid[sel];
  assign out_last = busy & req_last[sel];
  assign out_data = busy ? req_data[sel*W +: W] : '0;
  assign req_ready = grant & {N{out_ready}};
  assign xfer = out_valid & out_ready;
  assign rel = xfer & (out_last | cap_hit);
`ifdef MUX_ARB_BURST_CAP_EN
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  logic [CW-1:0] cnt;
  assign cap_hit = cnt == CW'(MAX_BURST - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= rel ? '0 : xfer ? cnt + 1'b1 : cnt;
`else
  assign cap_hit = 1'b0;
`endif
  // Scan downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      idx = SW'((int'(ptr) + i) % N);
      if (req_valid[idx]) win = idx;
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    sel_n = sel;
    grant_n = grant;
    if (state == IDLE && |req_valid) begin
      state_n = GRANT;
      sel_n = win;
      grant_n = N'(1) << win;
    end else if (state == GRANT && rel) begin
      state_n = IDLE;
      grant_n = '0;
      ptr_n = sel == SW'(N - 1) ? '0 : sel + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      sel <= sel_n;
      grant <= grant_n;
    end
endmodule
